// File: rtl/tdc_thermo_decoder_pkg.sv
// Shared sizing for the CARRY4 delay-line thermometer decoder.
package tdc_thermo_decoder_pkg;

    localparam int unsigned NCARRY4_DEFAULT  = 8;
    localparam int unsigned NTAPS_DEFAULT    = 4 * NCARRY4_DEFAULT;
    localparam int unsigned FINE_W_DEFAULT   = 6;
    localparam int unsigned COARSE_W_DEFAULT = 16;

    function automatic int unsigned ntaps_of(input int unsigned ncarry4);
        return 4 * ncarry4;
    endfunction

    // Smallest w with 2**w >= v; 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tdc_thermo_decoder_if.sv
// Tap input and hit-word output bundle of the thermometer decoder.
interface tdc_thermo_decoder_if
    import tdc_thermo_decoder_pkg::*;
#(
    parameter int unsigned NTAPS    = NTAPS_DEFAULT,
    parameter int unsigned FINE_W   = FINE_W_DEFAULT,
    parameter int unsigned COARSE_W = COARSE_W_DEFAULT
) ();

    logic                enable;
    logic [NTAPS-1:0]    taps;
    logic                valid;
    logic [FINE_W-1:0]   fine;
    logic [COARSE_W-1:0] coarse;
    logic                overflow;
    logic                bubble_err;

    modport master (
        output enable, taps,
        input  valid, fine, coarse, overflow, bubble_err
    );

    modport slave (
        input  enable, taps,
        output valid, fine, coarse, overflow, bubble_err
    );

endinterface

// File: rtl/tdc_thermo_decoder_popcount.sv
// Combinational ones-count of the corrected tap word.
module tdc_thermo_decoder_popcount
    import tdc_thermo_decoder_pkg::*;
#(
    parameter int unsigned NTAPS  = NTAPS_DEFAULT,
    parameter int unsigned FINE_W = FINE_W_DEFAULT
) (
    input  logic [NTAPS-1:0]  bits_i,
    output logic [FINE_W-1:0] count_o
);

    localparam int unsigned CntW = clog2(NTAPS + 1);

    logic [CntW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NTAPS; i++) begin
            sum = sum + CntW'(bits_i[i]);
        end
        count_o = FINE_W'(sum);
    end

endmodule

// File: rtl/tdc_thermo_decoder.sv
// Resynchronises the delay-line taps, majority-filters bubbles and emits one
// {coarse, fine} word per rising edge of tap0.
module tdc_thermo_decoder
    import tdc_thermo_decoder_pkg::*;
#(
    parameter int unsigned NCARRY4  = NCARRY4_DEFAULT,
    parameter int unsigned COARSE_W = COARSE_W_DEFAULT,
    parameter int unsigned FINE_W   = FINE_W_DEFAULT
) (
    input logic               clk,
    input logic               rst,
    tdc_thermo_decoder_if.slave bus
);

    localparam int unsigned NTAPS = ntaps_of(NCARRY4);

    logic [COARSE_W-1:0] cnt_q, cc1_q, cc2_q, cc3_q, coarse_q;
    logic [NTAPS-1:0]    s1_q, s2_q, c_q, c_d;
    logic [NTAPS+1:0]    ext;
    logic                prev0_q, hit, hit_c_q;
    logic                valid_q, overflow_q, bubble_q;
    logic [FINE_W-1:0]   fine_q, pop;

    // Line start reads as a one, line end as a zero.
    assign ext = {1'b0, s2_q, 1'b1};

    always_comb begin
        c_d = '0;
        for (int i = 0; i < NTAPS; i++) begin
            c_d[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
        end
    end

    assign hit = s2_q[0] & ~prev0_q & bus.enable;

    tdc_thermo_decoder_popcount #(
        .NTAPS  (NTAPS),
        .FINE_W (FINE_W)
    ) u_popcount (
        .bits_i  (c_q),
        .count_o (pop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            cc1_q      <= '0;
            cc2_q      <= '0;
            cc3_q      <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            c_q        <= '0;
            prev0_q    <= 1'b0;
            hit_c_q    <= 1'b0;
            valid_q    <= 1'b0;
            fine_q     <= '0;
            coarse_q   <= '0;
            overflow_q <= 1'b0;
            bubble_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_q + COARSE_W'(1);
            s1_q    <= bus.taps;
            cc1_q   <= cnt_q;
            s2_q    <= s1_q;
            cc2_q   <= cc1_q;
            prev0_q <= s2_q[0];
            c_q     <= c_d;
            hit_c_q <= hit;
            cc3_q   <= cc2_q;
            valid_q <= hit_c_q;
            if (hit_c_q) begin
                fine_q     <= pop;
                coarse_q   <= cc3_q;
                overflow_q <= &c_q;
                // A clean thermometer code has no carry-chain overlap with its increment.
                bubble_q   <= |(c_q & (c_q + NTAPS'(1)));
            end
        end
    end

    assign bus.valid      = valid_q;
    assign bus.fine       = fine_q;
    assign bus.coarse     = coarse_q;
    assign bus.overflow   = overflow_q;
    assign bus.bubble_err = bubble_q;

endmodule

// File: tb/tb_tdc_thermo_decoder.sv
// Scoreboard bench: a 16-bit and a 4-bit coarse instance driven with the same taps.
module tb_tdc_thermo_decoder;

    localparam int unsigned NT  = 32;
    localparam int unsigned FW  = 6;
    localparam int unsigned CWA = 16;
    localparam int unsigned CWB = 4;

    typedef struct {
        int          fine;
        int unsigned cnt;
        bit          ovf;
        bit          bub;
        longint      due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [NT-1:0] taps = '0;

    int     errors = 0;
    int     checks = 0;
    int     nvalid = 0;
    longint edge_no = 0;

    exp_t        q[$];
    exp_t        hold;
    logic [31:0] th[3];
    int unsigned ch[3];
    int unsigned cnt_m = 0;

    tdc_thermo_decoder_if #(.NTAPS(NT), .FINE_W(FW), .COARSE_W(CWA)) bus_a ();
    tdc_thermo_decoder_if #(.NTAPS(NT), .FINE_W(FW), .COARSE_W(CWB)) bus_b ();

    assign bus_a.taps   = taps;
    assign bus_a.enable = enable;
    assign bus_b.taps   = taps;
    assign bus_b.enable = enable;

    tdc_thermo_decoder #(.NCARRY4(8), .COARSE_W(CWA), .FINE_W(FW)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    tdc_thermo_decoder #(.NCARRY4(8), .COARSE_W(CWB), .FINE_W(FW)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference word: majority vote with a one below bit 0 and a zero above the top tap.
    function automatic exp_t make_exp(input logic [31:0] t, input int unsigned cnt);
        exp_t        e;
        logic [31:0] c;
        int          l, r;
        for (int i = 0; i < 32; i++) begin
            l = (i == 0)  ? 1 : int'(t[i-1]);
            r = (i == 31) ? 0 : int'(t[i+1]);
            c[i] = (l + int'(t[i]) + r) >= 2;
        end
        e.fine = $countones(c);
        e.cnt  = cnt;
        e.ovf  = (e.fine == 32);
        e.bub  = (64'(c) != ((64'(1) << e.fine) - 1));
        e.due  = 0;
        return e;
    endfunction

    // Model: a hit is a 0->1 step of sampled tap0, qualified by enable two edges later.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            edge_no++;
            if (rst) begin
                for (int i = 0; i < 3; i++) begin
                    th[i] = '0;
                    ch[i] = 0;
                end
                cnt_m = 0;
                q.delete();
                hold = '{fine: 0, cnt: 0, ovf: 0, bub: 0, due: 0};
            end else begin
                if (th[1][0] && !th[2][0] && enable) begin
                    e     = make_exp(th[1], ch[1]);
                    e.due = edge_no + 1;
                    q.push_back(e);
                end
                th[2] = th[1]; th[1] = th[0]; th[0] = taps;
                ch[2] = ch[1]; ch[1] = ch[0]; ch[0] = cnt_m;
                cnt_m++;
            end
        end
    end

    // Monitor: every negedge, valid must match the model and outputs must equal the last word.
    initial begin
        bit exp_v;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due < edge_no) void'(q.pop_front());
            exp_v = (q.size() > 0) && (q[0].due == edge_no);
            chk("valid_a", 64'(bus_a.valid), 64'(exp_v));
            chk("valid_b", 64'(bus_b.valid), 64'(exp_v));
            if (exp_v) begin
                hold = q.pop_front();
                nvalid++;
            end
            chk("fine_a", 64'(bus_a.fine), 64'(hold.fine));
            chk("coarse_a", 64'(bus_a.coarse), 64'(hold.cnt % (1 << CWA)));
            chk("overflow_a", 64'(bus_a.overflow), 64'(hold.ovf));
            chk("bubble_a", 64'(bus_a.bubble_err), 64'(hold.bub));
            chk("fine_b", 64'(bus_b.fine), 64'(hold.fine));
            chk("coarse_b", 64'(bus_b.coarse), 64'(hold.cnt % (1 << CWB)));
        end
    end

    // Single-sample pattern; the word appears on the fourth negedge after it is driven.
    task automatic directed(input string name, input logic [31:0] p, input int f,
                            input bit ovf, input bit bub);
        taps = p;
        @(negedge clk);
        taps = '0;
        repeat (3) @(negedge clk);
        chk({name, "_valid"}, 64'(bus_a.valid), 64'd1);
        chk({name, "_fine"}, 64'(bus_a.fine), 64'(f));
        chk({name, "_ovf"}, 64'(bus_a.overflow), 64'(ovf));
        chk({name, "_bub"}, 64'(bus_a.bubble_err), 64'(bub));
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse(input logic [31:0] p, input int hi, input int gap);
        taps = p;
        repeat (hi) @(negedge clk);
        taps = '0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int          base;
        int unsigned r, n;
        logic [31:0] w;

        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(bus_a.valid), 64'd0);
        chk("rst_fine", 64'(bus_a.fine), 64'd0);
        chk("rst_coarse", 64'(bus_a.coarse), 64'd0);
        chk("rst_ovf", 64'(bus_a.overflow), 64'd0);
        chk("rst_bub", 64'(bus_a.bubble_err), 64'd0);
        rst    = 1'b0;
        enable = 1'b1;

        // Edge with counter 20 samples 0xFF.
        repeat (20) @(negedge clk);
        taps = 32'h0000_00FF;
        repeat (4) @(negedge clk);
        chk("c20_valid", 64'(bus_a.valid), 64'd1);
        chk("c20_coarse", 64'(bus_a.coarse), 64'd20);
        chk("c20_fine", 64'(bus_a.fine), 64'd8);
        chk("c20_flags", {62'd0, bus_a.overflow, bus_a.bubble_err}, 64'd0);
        taps = '0;
        repeat (3) @(negedge clk);

        directed("bubble_f7", 32'h0000_00F7, 8, 1'b0, 1'b0);
        directed("split_0f0f", 32'h0000_0F0F, 8, 1'b0, 1'b1);
        directed("full", 32'hFFFF_FFFF, 32, 1'b1, 1'b0);

        base = nvalid;
        pulse(32'hFFFF_FFFF, 50, 3);
        pulse(32'hFFFF_FFFF, 5, 8);
        chk("two_pulses", 64'(nvalid - base), 64'd2);

        base   = nvalid;
        enable = 1'b0;
        pulse(32'h0000_000F, 3, 6);
        enable = 1'b1;
        chk("enable_off", 64'(nvalid - base), 64'd0);

        // Hit two edges into the pipe, then reset.
        base = nvalid;
        taps = 32'h0000_003F;
        repeat (2) @(negedge clk);
        taps = '0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        chk("flush_valid", 64'(bus_a.valid), 64'd0);
        chk("flush_fine", 64'(bus_a.fine), 64'd0);
        chk("flush_coarse", 64'(bus_a.coarse), 64'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("flush_none", 64'(nvalid - base), 64'd0);

        // 4-bit counter: hit at 15, then one three edges later reports 2.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16 && (cnt_m % 16) != 15; i++) @(negedge clk);
        taps = 32'h1; @(negedge clk);
        taps = 32'h0; @(negedge clk);
        @(negedge clk);
        taps = 32'h1; @(negedge clk);
        taps = 32'h0;
        chk("wrap15_valid", 64'(bus_b.valid), 64'd1);
        chk("wrap15_coarse", 64'(bus_b.coarse), 64'd15);
        repeat (3) @(negedge clk);
        chk("wrap2_valid", 64'(bus_b.valid), 64'd1);
        chk("wrap2_coarse", 64'(bus_b.coarse), 64'd2);
        repeat (3) @(negedge clk);

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                w = '0;
            end else if (r < 8) begin
                n = $urandom_range(1, 32);
                w = (n == 32) ? 32'hFFFF_FFFF : 32'((64'(1) << n) - 1);
                if (r >= 6) w[$urandom_range(0, 31)] ^= 1'b1;
            end else begin
                w = $urandom;
            end
            taps   = w;
            enable = ($urandom_range(0, 7) != 0);
            rst    = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        rst    = 1'b0;
        enable = 1'b1;
        taps   = '0;
        repeat (8) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
